// File: rtl/sa_tile_loader.sv
// sa_tile_loader: load sequencer for an N x N weight-stationary systolic array.
// One single-port read RAM is shared: a start pulse first preloads N*N weights
// (skipped when resident weights are reused), then streams FCOLS feature
// columns into the row inputs with diagonal skew and pulses done.
// Requires N >= 2.
module sa_tile_loader #(
    parameter int N     = 3,
    parameter int DW    = 8,
    parameter int AW    = 6,
    parameter int FCOLS = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              reuse_weights,
    input  logic [AW-1:0]     weight_baseaddr,
    input  logic [AW-1:0]     feature_baseaddr,
    output logic [AW-1:0]     ram_addr,
    input  logic [DW-1:0]     ram_q,
    output logic [DW-1:0]     wgt_data,
    output logic [N*N-1:0]    wgt_en,
    output logic [N*DW-1:0]   feat_row,
    output logic [N-1:0]      feat_valid,
    output logic              busy,
    output logic              done
);

    localparam int NN = N * N;
    localparam int NE = FCOLS * N;
    localparam int CW = $clog2(NN + NE + N + 2);
    localparam int IW = (NN > 1) ? $clog2(NN) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        W_LOAD  = 2'd1,
        F_LOAD  = 2'd2,
        F_DRAIN = 2'd3
    } state_t;

    state_t               state_r;
    logic [CW-1:0]        cnt_r;
    logic [AW-1:0]        wbase_r;
    logic [AW-1:0]        fbase_r;
    logic                 weights_loaded_r;
    logic [IW-1:0]        irow_r;

    // Read tags: issue stage travels with ram_addr, q stage lines up with ram_q
    logic                 rd_wgt_r;
    logic                 rd_feat_r;
    logic [IW-1:0]        rd_idx_r;
    logic                 q_wgt_r;
    logic                 q_feat_r;
    logic [IW-1:0]        q_idx_r;

    logic [N-2:0][DW-1:0] gbuf_r;
    logic [N-1:1][DW-1:0] lreg_r;
    logic [N-2:0]         vsh_r;
    logic [N-1:0][DW-1:0] frow_r;
    logic                 launch_s;

    // Row index of the element issued after row r (wraps at N-1)
    function automatic logic [IW-1:0] next_row(input logic [IW-1:0] r);
        if (r == IW'(N - 1)) begin
            return '0;
        end else begin
            return r + IW'(1);
        end
    endfunction

    // A column is complete when its last row word is on ram_q
    assign launch_s = q_feat_r && (q_idx_r == IW'(N - 1));
    assign feat_row = frow_r;

    // Control FSM: address generation, read tagging, busy/done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r          <= IDLE;
            cnt_r            <= '0;
            wbase_r          <= '0;
            fbase_r          <= '0;
            weights_loaded_r <= 1'b0;
            irow_r           <= '0;
            rd_wgt_r         <= 1'b0;
            rd_feat_r        <= 1'b0;
            rd_idx_r         <= '0;
            ram_addr         <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            rd_wgt_r  <= 1'b0;
            rd_feat_r <= 1'b0;
            done      <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        wbase_r  <= weight_baseaddr;
                        fbase_r  <= feature_baseaddr;
                        busy     <= 1'b1;
                        cnt_r    <= CW'(1);
                        rd_idx_r <= '0;
                        if (reuse_weights && weights_loaded_r) begin
                            state_r   <= F_LOAD;
                            ram_addr  <= feature_baseaddr;
                            rd_feat_r <= 1'b1;
                            irow_r    <= next_row('0);
                        end else begin
                            state_r  <= W_LOAD;
                            ram_addr <= weight_baseaddr;
                            rd_wgt_r <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                W_LOAD: begin
                    if (cnt_r == CW'(NN)) begin
                        // Last weight address already out: go straight to features
                        state_r          <= F_LOAD;
                        weights_loaded_r <= 1'b1;
                        ram_addr         <= fbase_r;
                        rd_feat_r        <= 1'b1;
                        rd_idx_r         <= '0;
                        irow_r           <= next_row('0);
                        cnt_r            <= CW'(1);
                    end else begin
                        ram_addr <= wbase_r + AW'(cnt_r);
                        rd_wgt_r <= 1'b1;
                        rd_idx_r <= IW'(cnt_r);
                        cnt_r    <= cnt_r + CW'(1);
                    end
                end
                F_LOAD: begin
                    if (cnt_r == CW'(NE)) begin
                        state_r <= F_DRAIN;
                        cnt_r   <= '0;
                    end else begin
                        ram_addr  <= fbase_r + AW'(cnt_r);
                        rd_feat_r <= 1'b1;
                        rd_idx_r  <= irow_r;
                        irow_r    <= next_row(irow_r);
                        cnt_r     <= cnt_r + CW'(1);
                    end
                end
                F_DRAIN: begin
                    // N+1 cycles until the last skewed row is out, then the done cycle
                    if (cnt_r == CW'(N + 1)) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                        cnt_r   <= '0;
                    end else begin
                        if (cnt_r == CW'(N)) begin
                            done <= 1'b1;
                        end else begin
                            done <= 1'b0;
                        end
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Align read tags with RAM data and register the weight outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_wgt_r  <= 1'b0;
            q_feat_r <= 1'b0;
            q_idx_r  <= '0;
            wgt_data <= '0;
            wgt_en   <= '0;
        end else begin
            q_wgt_r  <= rd_wgt_r;
            q_feat_r <= rd_feat_r;
            q_idx_r  <= rd_idx_r;
            if (q_wgt_r) begin
                wgt_data <= ram_q;
                wgt_en   <= {{(NN-1){1'b0}}, 1'b1} << q_idx_r;
            end else begin
                wgt_en   <= '0;
            end
        end
    end

    // Gather feature columns, launch them and skew row i by i cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gbuf_r     <= '0;
            lreg_r     <= '0;
            vsh_r      <= '0;
            frow_r     <= '0;
            feat_valid <= '0;
        end else begin
            for (int i = 0; i < N - 1; i++) begin
                if (q_feat_r && (q_idx_r == IW'(i))) begin
                    gbuf_r[i] <= ram_q;
                end
            end
            if (launch_s) begin
                frow_r[0]     <= gbuf_r[0];
                for (int i = 1; i < N - 1; i++) begin
                    lreg_r[i] <= gbuf_r[i];
                end
                lreg_r[N-1]   <= ram_q;
            end
            feat_valid[0] <= launch_s;
            vsh_r[0]      <= launch_s;
            for (int s = 1; s < N - 1; s++) begin
                vsh_r[s] <= vsh_r[s-1];
            end
            for (int i = 1; i < N; i++) begin
                feat_valid[i] <= vsh_r[i-1];
                if (vsh_r[i-1]) begin
                    frow_r[i] <= lreg_r[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_sa_tile_loader.sv
// Self-checking bench for sa_tile_loader (N=3, FCOLS=3, AW=6).
// Expected per-cycle behaviour is derived from the timing formulas of the
// tile schedule; a directed table plus a randomized phase drive the tiles.
module tb_sa_tile_loader;

    localparam int N     = 3;
    localparam int DW    = 8;
    localparam int AW    = 6;
    localparam int FCOLS = 3;
    localparam int NN    = N * N;
    localparam int NE    = FCOLS * N;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              reuse_weights = 1'b0;
    logic [AW-1:0]     weight_baseaddr = '0;
    logic [AW-1:0]     feature_baseaddr = '0;
    logic [AW-1:0]     ram_addr;
    logic [DW-1:0]     ram_q;
    logic [DW-1:0]     wgt_data;
    logic [NN-1:0]     wgt_en;
    logic [N*DW-1:0]   feat_row;
    logic [N-1:0]      feat_valid;
    logic              busy;
    logic              done;

    logic [DW-1:0]     mem [0:63];

    int checks   = 0;
    int failures = 0;
    bit wl_m     = 1'b0;
    int last_addr_m = 0;

    typedef struct {
        int wb;
        int fb;
        bit reuse;
        bit inj;
        int abort_c;
        int exp_pulses;
        int exp_done;
    } vec_t;

    vec_t vecs [7];

    sa_tile_loader #(.N(N), .DW(DW), .AW(AW), .FCOLS(FCOLS)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .reuse_weights    (reuse_weights),
        .weight_baseaddr  (weight_baseaddr),
        .feature_baseaddr (feature_baseaddr),
        .ram_addr         (ram_addr),
        .ram_q            (ram_q),
        .wgt_data         (wgt_data),
        .wgt_en           (wgt_en),
        .feat_row         (feat_row),
        .feat_valid       (feat_valid),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    // Synchronous single-port read RAM: data the cycle after the address
    always @(posedge clk) ram_q <= mem[ram_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one tile from the current negedge (its cycle 0) and checks every cycle.
    task automatic run_tile(input int wb, input int fb, input bit reuse, input bit inj,
                            input int abort_c, output int pulses, output int done_c);
        bit pre;
        int f0, d, last_c, ea;
        bit ev;
        logic [DW-1:0] ed;
        pre    = !(reuse && wl_m);
        f0     = pre ? NN + 1 : 1;
        d      = f0 + (FCOLS + 1) * N + 1;
        last_c = (abort_c > 0) ? abort_c : d + 1;
        weight_baseaddr  = AW'(wb);
        feature_baseaddr = AW'(fb);
        reuse_weights    = reuse;
        start            = 1'b1;
        pulses = 0;
        done_c = 0;
        for (int c = 1; c <= last_c; c++) begin
            @(negedge clk);
            ea = last_addr_m;
            if (pre && c >= 1 && c <= NN) ea = (wb + c - 1) & 63;
            if (c >= f0 && c < f0 + NE) ea = (fb + c - f0) & 63;
            last_addr_m = ea;
            chk($sformatf("ram_addr c%0d", c), 64'(ram_addr), 64'(ea));
            if (pre && c >= 3 && c <= NN + 2) begin
                chk($sformatf("wgt_en c%0d", c), 64'(wgt_en), 64'(1) << (c - 3));
                chk($sformatf("wgt_data c%0d", c), 64'(wgt_data), 64'(mem[(wb + c - 3) & 63]));
            end else begin
                chk($sformatf("wgt_en c%0d", c), 64'(wgt_en), 64'(0));
            end
            for (int i = 0; i < N; i++) begin
                ev = 1'b0;
                ed = '0;
                for (int j = 0; j < FCOLS; j++) begin
                    if (c == f0 + (j + 1) * N + 1 + i) begin
                        ev = 1'b1;
                        ed = mem[(fb + j * N + i) & 63];
                    end
                end
                chk($sformatf("feat_valid[%0d] c%0d", i, c), 64'(feat_valid[i]), 64'(ev));
                if (ev) chk($sformatf("feat_row[%0d] c%0d", i, c), 64'(feat_row[i*DW +: DW]), 64'(ed));
            end
            chk($sformatf("done c%0d", c), 64'(done), 64'(c == d));
            chk($sformatf("busy c%0d", c), 64'(busy), 64'(c >= 1 && c <= d));
            if (wgt_en != '0) pulses++;
            if (done === 1'b1 && done_c == 0) done_c = c;
            // inputs for the next edge; optional ignored start in cycle 8
            start = inj && (c == 8);
            if (inj && c == 8) begin
                weight_baseaddr  = AW'(wb ^ 5);
                feature_baseaddr = AW'(fb ^ 7);
                reuse_weights    = ~reuse;
            end
        end
        if (abort_c > 0) begin
            rst   = 1'b0;
            start = 1'b0;
            #1;
            chk("reset_abort outputs", {ram_addr, wgt_data, wgt_en, feat_row, feat_valid, busy, done}, '0);
            wl_m = 1'b0;
            last_addr_m = 0;
            @(negedge clk);
            @(negedge clk);
            rst = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk("post_abort done", 64'(done), 64'(0));
                chk("post_abort busy", 64'(busy), 64'(0));
            end
        end else if (pre) begin
            wl_m = 1'b1;
        end
    endtask

    initial begin
        int pulses, done_c, exp_p, exp_d;
        int wb, fb;
        bit rw, inj;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset outputs", {ram_addr, wgt_data, wgt_en, feat_row, feat_valid, busy, done}, '0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle busy", 64'(busy), 64'(0));

        for (int a = 0; a < 64; a++) mem[a] = DW'(a);

        //          wb  fb  reuse inj abort pulses done
        vecs[0] = '{0,  16, 1'b0, 1'b0, 0,  9, 23};  // preload + stream
        vecs[1] = '{0,  32, 1'b1, 1'b0, 0,  0, 14};  // reuse resident weights
        vecs[2] = '{5,  60, 1'b1, 1'b0, 0,  0, 14};  // feature address wrap
        vecs[3] = '{10, 20, 1'b0, 1'b1, 0,  9, 23};  // start while busy ignored
        vecs[4] = '{0,  16, 1'b0, 1'b0, 12, 9, 0};   // reset mid-tile
        vecs[5] = '{0,  40, 1'b1, 1'b0, 0,  9, 23};  // reuse after reset -> preload
        vecs[6] = '{60, 3,  1'b0, 1'b0, 0,  9, 23};  // weight address wrap

        for (int v = 0; v < 7; v++) begin
            run_tile(vecs[v].wb, vecs[v].fb, vecs[v].reuse, vecs[v].inj, vecs[v].abort_c, pulses, done_c);
            chk($sformatf("vec%0d wgt pulses", v), 64'(pulses), 64'(vecs[v].exp_pulses));
            chk($sformatf("vec%0d done cycle", v), 64'(done_c), 64'(vecs[v].exp_done));
        end

        for (int t = 0; t < 20; t++) begin
            for (int a = 0; a < 64; a++) mem[a] = DW'($urandom);
            wb  = int'($urandom_range(0, 63));
            fb  = int'($urandom_range(0, 63));
            rw  = 1'($urandom_range(0, 1));
            inj = 1'($urandom_range(0, 1));
            exp_p = (rw && wl_m) ? 0 : NN;
            exp_d = ((rw && wl_m) ? 1 : NN + 1) + (FCOLS + 1) * N + 1;
            run_tile(wb, fb, rw, inj, 0, pulses, done_c);
            chk($sformatf("rnd%0d wgt pulses", t), 64'(pulses), 64'(exp_p));
            chk($sformatf("rnd%0d done cycle", t), 64'(done_c), 64'(exp_d));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sa_tile_loader.md
# sa_tile_loader

Parametrised load sequencer for an N×N weight-stationary systolic array, sharing one single-port read RAM between weight preload and feature streaming. A `start` pulse first preloads N·N weights into the array's B registers (skipped when the resident weights are reused). It then streams FCOLS feature columns into the array's row inputs with diagonal skew and pulses `done`. It sits between the tile RAM and `systolic_array` and generalises the fixed 3×3 loader pair.

## Interface
- N, 3, array dimension; rows and columns of the weight block
- DW, 8, data width of RAM words, weights and features
- AW, 6, RAM address width
- FCOLS, 3, feature columns streamed per start; ≥1
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  begin a tile; sampled only in IDLE
- reuse_weights  in  1  with start: skip preload if weights are resident
- weight_baseaddr  in  AW  first weight word, sampled with start
- feature_baseaddr  in  AW  first feature word, sampled with start
- ram_addr  out  AW  registered RAM read address
- ram_q  in  DW  RAM read data, valid the cycle after its address
- wgt_data  out  DW  registered weight word
- wgt_en  out  N*N  one-hot B-register enable; bit k = row k/N, col k%N
- feat_row  out  N*DW  row i at bits [i*DW +: DW]
- feat_valid  out  N  per-row valid, skewed
- busy  out  1  high from the cycle after start is accepted through the done cycle
- done  out  1  one-cycle pulse at tile end

## Operation
- States: IDLE, W_LOAD, F_LOAD, F_DRAIN.
- IDLE:
  - On start, latch base addresses and go to W_LOAD.
  - Go to F_LOAD instead when reuse_weights=1 and weights_loaded=1.
  - start in any other state is ignored.
- W_LOAD:
  - Counter k = 0..N·N−1 drives ram_addr = weight_baseaddr+k, one per cycle.
  - Each returned word drives wgt_data with wgt_en = 1<<k.
  - After the last address, set weights_loaded and go to F_LOAD with no bubble.
- F_LOAD:
  - Element e = j·N+i (column j, row i; column-major) is read from feature_baseaddr+e, one per cycle, for e = 0..FCOLS·N−1.
  - Returned words fill a gather buffer.
  - A completed column moves to a launch register, so gathering of column j+1 overlaps launch of column j.
- Skew: launched column j drives row i from a delay line of depth i. feat_valid[i] is high for exactly one cycle per column.
- F_DRAIN: entered after the last address is issued. Runs until row N−1 of the last column has been output. The following cycle pulses done, then returns to IDLE.
- Address arithmetic is modulo 2^AW; base+offset wraps silently.
- weights_loaded is cleared only by reset. reuse_weights=1 with weights_loaded=0 performs a full preload.
- Reset mid-operation: abort immediately, return to IDLE, clear weights_loaded and all buffers.

## Timing
- Reset values:
  - ram_addr, wgt_data, feat_row: 0.
  - wgt_en, feat_valid: 0.
  - busy, done: 0.
  - state: IDLE.
- Cycle 0 is the cycle in which start is sampled high in IDLE.
- Preload (W_LOAD): address k is driven in cycle 1+k; wgt_en[k] and wgt_data are valid in cycle 3+k.
- F0 is the cycle of the first feature address: N·N+1 with preload, 1 when preload is skipped.
- Feature element e: address driven in cycle F0+e.
- Row output: row i of column j is valid in cycle F0+(j+1)·N+1+i.
- done is asserted in cycle F0+(FCOLS+1)·N+1. busy is low from the next cycle, and a new start is accepted in that cycle.
- The last wgt_en (cycle N·N+2) always precedes the first feat_valid (cycle N·N+N+2).
- ram_addr holds its last value whenever no read is issued.

## Test plan
- Preload + stream: N=3, FCOLS=3, mem[a]=a, weight_baseaddr=0, feature_baseaddr=16.
  - Weights: wgt_data=k with wgt_en=1<<k in cycles 3..11.
  - Column 0: feat_row[0]=16 @14, [1]=17 @15, [2]=18 @16; column 2 row 2 = 24 @22.
  - Tile end: done @23; busy high cycles 1..23.
- Reuse: after the test above, start with reuse_weights=1, feature_baseaddr=32.
  - No wgt_en pulses.
  - feat_row[0]=32 @5; done @14.
- Reuse after reset: assert reset, then start with reuse_weights=1 → full preload runs; done @23.
- Address wrap: feature_baseaddr=60 → ram_addr sequence 60,61,62,63,0,1,…,4; row outputs carry mem[60..63], mem[0..4].
- Start while busy: pulse start in cycle 8 with different bases → ignored; addresses and done cycle unchanged.
- Reset mid-tile: drop rst in cycle 12.
  - All outputs 0 and state IDLE immediately; no done pulse.
  - A subsequent start runs a full preload.
